// File: rtl/per2axi_req_channel.sv
`default_nettype none
// ============================================================================
// Module      : per2axi_req_channel
// Description : Peripheral-to-AXI request path; single outstanding transaction.
// Revision    : 1.0 - initial release
// ============================================================================
module per2axi_req_channel #(
  parameter int PER_ADDR_WIDTH = 32,
  parameter int PER_ID_WIDTH   = 5,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_USER_WIDTH = 6,
  parameter int AXI_ID_WIDTH   = 5,
  parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH/8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,

  input  logic                      per_slave_req_i,
  input  logic [PER_ADDR_WIDTH-1:0] per_slave_add_i,
  input  logic                      per_slave_we_i,
  input  logic [31:0]               per_slave_wdata_i,
  input  logic [3:0]                per_slave_be_i,
  input  logic [PER_ID_WIDTH-1:0]   per_slave_id_i,
  output logic                      per_slave_gnt_o,

  output logic                      axi_master_ar_valid_o,
  input  logic                      axi_master_ar_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0] axi_master_ar_addr_o,
  output logic [AXI_ID_WIDTH-1:0]   axi_master_ar_id_o,
  output logic [2:0]                axi_master_ar_prot_o,
  output logic [3:0]                axi_master_ar_region_o,
  output logic [7:0]                axi_master_ar_len_o,
  output logic [2:0]                axi_master_ar_size_o,
  output logic [1:0]                axi_master_ar_burst_o,
  output logic                      axi_master_ar_lock_o,
  output logic [3:0]                axi_master_ar_cache_o,
  output logic [3:0]                axi_master_ar_qos_o,
  output logic [AXI_USER_WIDTH-1:0] axi_master_ar_user_o,

  output logic                      axi_master_aw_valid_o,
  input  logic                      axi_master_aw_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0] axi_master_aw_addr_o,
  output logic [AXI_ID_WIDTH-1:0]   axi_master_aw_id_o,
  output logic [2:0]                axi_master_aw_prot_o,
  output logic [3:0]                axi_master_aw_region_o,
  output logic [7:0]                axi_master_aw_len_o,
  output logic [2:0]                axi_master_aw_size_o,
  output logic [1:0]                axi_master_aw_burst_o,
  output logic                      axi_master_aw_lock_o,
  output logic [3:0]                axi_master_aw_cache_o,
  output logic [3:0]                axi_master_aw_qos_o,
  output logic [AXI_USER_WIDTH-1:0] axi_master_aw_user_o,

  output logic                      axi_master_w_valid_o,
  input  logic                      axi_master_w_ready_i,
  output logic [AXI_DATA_WIDTH-1:0] axi_master_w_data_o,
  output logic [AXI_STRB_WIDTH-1:0] axi_master_w_strb_o,
  output logic [AXI_USER_WIDTH-1:0] axi_master_w_user_o,
  output logic                      axi_master_w_last_o,

  output logic                      trans_req_o,
  output logic                      trans_we_o,
  output logic [PER_ID_WIDTH-1:0]   trans_id_o,
  output logic [PER_ADDR_WIDTH-1:0] trans_add_o,
  input  logic                      trans_r_valid_i
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    AR_ISSUE = 2'd1,
    WR_ISSUE = 2'd2,
    PENDING  = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [PER_ADDR_WIDTH-1:0] r_addr;
  logic                      r_we;
  logic [31:0]               r_wdata;
  logic [3:0]                r_be;
  logic [PER_ID_WIDTH-1:0]   r_id;
  logic                      r_aw_done;
  logic                      r_w_done;
  logic                      w_aw_hs;
  logic                      w_w_hs;

  assign w_aw_hs = axi_master_aw_valid_o & axi_master_aw_ready_i;
  assign w_w_hs  = axi_master_w_valid_o  & axi_master_w_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_id      <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && per_slave_req_i) begin
        r_addr    <= per_slave_add_i;
        r_we      <= per_slave_we_i;
        r_wdata   <= per_slave_wdata_i;
        r_be      <= per_slave_be_i;
        r_id      <= per_slave_id_i;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else if (r_state == WR_ISSUE) begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt           = r_state;
    per_slave_gnt_o       = 1'b0;
    axi_master_ar_valid_o = 1'b0;
    axi_master_aw_valid_o = 1'b0;
    axi_master_w_valid_o  = 1'b0;
    trans_req_o           = 1'b0;
    case (r_state)
      IDLE: begin
        per_slave_gnt_o = per_slave_req_i;
        if (per_slave_req_i) w_state_nxt = per_slave_we_i ? AR_ISSUE : WR_ISSUE;
      end
      AR_ISSUE: begin
        axi_master_ar_valid_o = 1'b1;
        if (axi_master_ar_ready_i) begin
          trans_req_o = 1'b1;
          w_state_nxt = PENDING;
        end
      end
      WR_ISSUE: begin
        axi_master_aw_valid_o = !r_aw_done;
        axi_master_w_valid_o  = !r_w_done;
        // Issue once both channels are done, counting handshakes of this cycle.
        if ((r_aw_done || (!r_aw_done && axi_master_aw_ready_i)) &&
            (r_w_done  || (!r_w_done  && axi_master_w_ready_i))) begin
          trans_req_o = 1'b1;
          w_state_nxt = PENDING;
        end
      end
      PENDING: begin
        if (trans_r_valid_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign axi_master_ar_addr_o   = AXI_ADDR_WIDTH'(r_addr);
  assign axi_master_ar_id_o     = AXI_ID_WIDTH'(r_id);
  assign axi_master_ar_prot_o   = 3'b000;
  assign axi_master_ar_region_o = 4'b0000;
  assign axi_master_ar_len_o    = 8'h00;
  assign axi_master_ar_size_o   = 3'b010;
  assign axi_master_ar_burst_o  = 2'b01;
  assign axi_master_ar_lock_o   = 1'b0;
  assign axi_master_ar_cache_o  = 4'b0000;
  assign axi_master_ar_qos_o    = 4'b0000;
  assign axi_master_ar_user_o   = '0;

  assign axi_master_aw_addr_o   = AXI_ADDR_WIDTH'(r_addr);
  assign axi_master_aw_id_o     = AXI_ID_WIDTH'(r_id);
  assign axi_master_aw_prot_o   = 3'b000;
  assign axi_master_aw_region_o = 4'b0000;
  assign axi_master_aw_len_o    = 8'h00;
  assign axi_master_aw_size_o   = 3'b010;
  assign axi_master_aw_burst_o  = 2'b01;
  assign axi_master_aw_lock_o   = 1'b0;
  assign axi_master_aw_cache_o  = 4'b0000;
  assign axi_master_aw_qos_o    = 4'b0000;
  assign axi_master_aw_user_o   = '0;

  // The 32-bit word is replicated so either lane of the 64-bit bus carries it.
  assign axi_master_w_data_o = {r_wdata, r_wdata};
  assign axi_master_w_strb_o = r_addr[2] ? {r_be, 4'b0000} : {4'b0000, r_be};
  assign axi_master_w_user_o = '0;
  assign axi_master_w_last_o = 1'b1;

  assign trans_we_o  = r_we;
  assign trans_id_o  = r_id;
  assign trans_add_o = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_per2axi_req_channel.sv
`default_nettype none
// ============================================================================
// Module      : tb_per2axi_req_channel
// Description : Directed, table-driven bench for the per2axi request channel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_per2axi_req_channel;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        per_slave_req_i;
  logic [31:0] per_slave_add_i;
  logic        per_slave_we_i;
  logic [31:0] per_slave_wdata_i;
  logic [3:0]  per_slave_be_i;
  logic [4:0]  per_slave_id_i;
  logic        per_slave_gnt_o;
  logic        ar_valid, ar_ready, aw_valid, aw_ready, w_valid, w_ready;
  logic [31:0] ar_addr, aw_addr;
  logic [4:0]  ar_id, aw_id;
  logic [2:0]  ar_prot, aw_prot, ar_size, aw_size;
  logic [3:0]  ar_region, aw_region, ar_cache, aw_cache, ar_qos, aw_qos;
  logic [7:0]  ar_len, aw_len;
  logic [1:0]  ar_burst, aw_burst;
  logic        ar_lock, aw_lock;
  logic [5:0]  ar_user, aw_user, w_user;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        w_last;
  logic        trans_req_o, trans_we_o, trans_r_valid_i;
  logic [4:0]  trans_id_o;
  logic [31:0] trans_add_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  per2axi_req_channel dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .per_slave_req_i(per_slave_req_i), .per_slave_add_i(per_slave_add_i),
    .per_slave_we_i(per_slave_we_i), .per_slave_wdata_i(per_slave_wdata_i),
    .per_slave_be_i(per_slave_be_i), .per_slave_id_i(per_slave_id_i),
    .per_slave_gnt_o(per_slave_gnt_o),
    .axi_master_ar_valid_o(ar_valid), .axi_master_ar_ready_i(ar_ready),
    .axi_master_ar_addr_o(ar_addr), .axi_master_ar_id_o(ar_id),
    .axi_master_ar_prot_o(ar_prot), .axi_master_ar_region_o(ar_region),
    .axi_master_ar_len_o(ar_len), .axi_master_ar_size_o(ar_size),
    .axi_master_ar_burst_o(ar_burst), .axi_master_ar_lock_o(ar_lock),
    .axi_master_ar_cache_o(ar_cache), .axi_master_ar_qos_o(ar_qos),
    .axi_master_ar_user_o(ar_user),
    .axi_master_aw_valid_o(aw_valid), .axi_master_aw_ready_i(aw_ready),
    .axi_master_aw_addr_o(aw_addr), .axi_master_aw_id_o(aw_id),
    .axi_master_aw_prot_o(aw_prot), .axi_master_aw_region_o(aw_region),
    .axi_master_aw_len_o(aw_len), .axi_master_aw_size_o(aw_size),
    .axi_master_aw_burst_o(aw_burst), .axi_master_aw_lock_o(aw_lock),
    .axi_master_aw_cache_o(aw_cache), .axi_master_aw_qos_o(aw_qos),
    .axi_master_aw_user_o(aw_user),
    .axi_master_w_valid_o(w_valid), .axi_master_w_ready_i(w_ready),
    .axi_master_w_data_o(w_data), .axi_master_w_strb_o(w_strb),
    .axi_master_w_user_o(w_user), .axi_master_w_last_o(w_last),
    .trans_req_o(trans_req_o), .trans_we_o(trans_we_o),
    .trans_id_o(trans_id_o), .trans_add_o(trans_add_o),
    .trans_r_valid_i(trans_r_valid_i)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [4:0]  id;
    logic [63:0] exp_data;
    logic [7:0]  exp_strb;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, input logic [4:0] id);
    per_slave_req_i   = 1'b1;
    per_slave_we_i    = we;
    per_slave_add_i   = a;
    per_slave_wdata_i = d;
    per_slave_be_i    = be;
    per_slave_id_i    = id;
  endtask

  // From PENDING: pulse completion, then confirm a fresh grant is possible.
  task automatic complete(input string nm);
    trans_r_valid_i = 1'b1;
    tick();
    trans_r_valid_i = 1'b0;
    per_slave_req_i = 1'b1;
    #1 chk({nm, "_gnt_after_done"}, per_slave_gnt_o, 1'b1);
    per_slave_req_i = 1'b0;
    #1;
  endtask

  int pulses;

  initial begin
    vecs[0] = '{1'b1, 32'h1000_0004, 32'h0,         4'h0,    5'd5,  64'h0, 8'h00};
    vecs[1] = '{1'b0, 32'h2000_0004, 32'hDEADBEEF, 4'b0110, 5'd3,  64'hDEADBEEF_DEADBEEF, 8'h60};
    vecs[2] = '{1'b0, 32'h2000_0000, 32'h1234_5678, 4'hF,   5'd1,  64'h12345678_12345678, 8'h0F};
    vecs[3] = '{1'b0, 32'h0000_000C, 32'hA5A5_0001, 4'b1001, 5'd31, 64'hA5A50001_A5A50001, 8'h90};
    vecs[4] = '{1'b1, 32'hFFFF_FFF8, 32'h0,         4'h0,    5'd31, 64'h0, 8'h00};

    rst_ni = 1'b0; per_slave_req_i = 1'b0; per_slave_add_i = '0; per_slave_we_i = 1'b0;
    per_slave_wdata_i = '0; per_slave_be_i = '0; per_slave_id_i = '0;
    ar_ready = 1'b0; aw_ready = 1'b0; w_ready = 1'b0; trans_r_valid_i = 1'b0;
    #1;
    chk("rst_valids", {ar_valid, aw_valid, w_valid, trans_req_o}, 4'b0);
    chk("rst_latched", {trans_we_o, trans_id_o, trans_add_o}, 38'h0);
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      ar_ready = 1'b1; aw_ready = 1'b1; w_ready = 1'b1;
      drive_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].id);
      #1 chk("v_gnt0", per_slave_gnt_o, 1'b1);
      tick();
      per_slave_req_i = 1'b0;
      #1;
      chk("v_trans_req", trans_req_o, 1'b1);
      chk("v_trans_info", {trans_we_o, trans_id_o, trans_add_o}, {vecs[i].we, vecs[i].id, vecs[i].addr});
      if (vecs[i].we) begin
        chk("v_ar_valids", {ar_valid, aw_valid, w_valid}, 3'b100);
        chk("v_ar_addr_id", {ar_addr, ar_id}, {vecs[i].addr, vecs[i].id});
        chk("v_ar_attr", {ar_len, ar_size, ar_burst}, {8'h00, 3'b010, 2'b01});
        chk("v_ar_zero", {ar_prot, ar_region, ar_lock, ar_cache, ar_qos, ar_user}, 24'h0);
      end else begin
        chk("v_wr_valids", {ar_valid, aw_valid, w_valid}, 3'b011);
        chk("v_aw_addr_id", {aw_addr, aw_id}, {vecs[i].addr, vecs[i].id});
        chk("v_aw_attr", {aw_len, aw_size, aw_burst}, {8'h00, 3'b010, 2'b01});
        chk("v_aw_zero", {aw_prot, aw_region, aw_lock, aw_cache, aw_qos, aw_user}, 24'h0);
        chk("v_w_data", w_data, vecs[i].exp_data);
        chk("v_w_strb", w_strb, vecs[i].exp_strb);
        chk("v_w_last_user", {w_last, w_user}, 7'b1_000000);
      end
      tick();
      per_slave_req_i = 1'b1;
      #1;
      chk("v_pend_gnt", per_slave_gnt_o, 1'b0);
      chk("v_pend_out", {ar_valid, aw_valid, w_valid, trans_req_o}, 4'b0);
      per_slave_req_i = 1'b0;
      complete("v");
    end

    // W delayed: AW at cycle 1, W at cycle 4
    aw_ready = 1'b1; w_ready = 1'b0;
    drive_req(1'b0, 32'h3000_0000, 32'hCAFE_F00D, 4'hF, 5'd7);
    tick(); per_slave_req_i = 1'b0;
    #1 chk("wd_c1", {aw_valid, w_valid, trans_req_o}, 3'b110);
    chk("wd_strb", w_strb, 8'h0F);
    for (int c = 2; c <= 3; c++) begin
      tick();
      #1 chk("wd_wait", {aw_valid, w_valid, trans_req_o}, 3'b010);
    end
    tick(); w_ready = 1'b1;
    #1 chk("wd_c4", {aw_valid, w_valid, trans_req_o}, 3'b011);
    tick();
    #1 chk("wd_pend", {aw_valid, w_valid, trans_req_o}, 3'b000);
    complete("wd");

    // AW delayed: W at cycle 1, AW at cycle 3
    aw_ready = 1'b0; w_ready = 1'b1; pulses = 0;
    drive_req(1'b0, 32'h3000_0004, 32'h0BAD_CAFE, 4'h3, 5'd9);
    tick(); per_slave_req_i = 1'b0;
    #1 chk("ad_c1", {aw_valid, w_valid, trans_req_o}, 3'b110);
    pulses += int'(trans_req_o);
    tick();
    #1 chk("ad_c2", {aw_valid, w_valid, trans_req_o}, 3'b100);
    pulses += int'(trans_req_o);
    tick(); aw_ready = 1'b1;
    #1 chk("ad_c3", {aw_valid, w_valid, trans_req_o}, 3'b101);
    pulses += int'(trans_req_o);
    for (int c = 4; c <= 5; c++) begin
      tick();
      #1 pulses += int'(trans_req_o);
    end
    chk("ad_pulses", pulses, 1);
    complete("ad");

    // AR stall with moving peripheral address and stray completion pulse
    ar_ready = 1'b0;
    drive_req(1'b1, 32'h4000_0010, 32'h0, 4'h0, 5'd12);
    for (int c = 1; c <= 5; c++) begin
      tick();
      per_slave_add_i = 32'h5000_0000 + c;
      trans_r_valid_i = (c == 3);
      #1;
      chk("st_ar", {ar_valid, ar_addr, ar_id}, {1'b1, 32'h4000_0010, 5'd12});
      chk("st_gnt_req", {per_slave_gnt_o, trans_req_o}, 2'b00);
    end
    tick(); trans_r_valid_i = 1'b0; per_slave_req_i = 1'b0; ar_ready = 1'b1;
    #1 chk("st_issue", {ar_valid, ar_addr, trans_req_o}, {1'b1, 32'h4000_0010, 1'b1});
    tick();
    #1 chk("st_pend", {ar_valid, trans_req_o}, 2'b00);
    complete("st");

    // Reset mid-write after AW handshake
    aw_ready = 1'b1; w_ready = 1'b0;
    drive_req(1'b0, 32'h6000_0000, 32'h1111_2222, 4'hF, 5'd2);
    tick(); per_slave_req_i = 1'b0;
    tick();
    #1 chk("rs_pre", {aw_valid, w_valid}, 2'b01);
    rst_ni = 1'b0;
    #1 chk("rs_drop", {ar_valid, aw_valid, w_valid, trans_req_o}, 4'b0);
    chk("rs_addr", trans_add_o, 32'h0);
    #1 rst_ni = 1'b1;
    tick();
    aw_ready = 1'b0; w_ready = 1'b0;
    drive_req(1'b0, 32'h6000_0008, 32'h3333_4444, 4'h1, 5'd4);
    #1 chk("rs_gnt", per_slave_gnt_o, 1'b1);
    tick(); per_slave_req_i = 1'b0;
    #1 chk("rs_both", {aw_valid, w_valid, trans_req_o}, 3'b110);
    aw_ready = 1'b1; w_ready = 1'b1;
    #1 chk("rs_issue", trans_req_o, 1'b1);
    tick();
    complete("rs");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
